// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM states, error codes and mouse command bytes.
// Used by the host transmitter and the mouse receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_BITS      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_ERR       = 3'd6
   } ps2_state_e;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_START = 2'd1;
   localparam logic [1:0] ERR_XFER  = 2'd2;
   localparam logic [1:0] ERR_NACK  = 2'd3;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] RESP_ACK     = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between the mouse controller
// and the PS/2 host transmitter.
interface ps2_host_tx_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;
   logic [1:0] err_code;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_busy, tx_done, tx_error, err_code
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_busy, tx_done, tx_error, err_code
   );
endinterface

// File: rtl/ps2_line_sync.sv
// Multi-flop synchronizer for one PS/2 pad with a falling-edge pulse.
// Shared by the host transmitter and the mouse receiver.
module ps2_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_q;
   logic                   r_prev;

   // Idle PS/2 lines float high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q    <= '1;
         r_prev <= 1'b1;
      end else begin
         r_q    <= {r_q[SYNC_STAGES-2:0], i_line};
         r_prev <= r_q[SYNC_STAGES-1];
      end
   end

   assign o_level = r_q[SYNC_STAGES-1];
   assign o_fall  = r_prev & ~r_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out
// eight data bits with odd parity and stop, then check the device ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int START_TIMEOUT  = 1500000,
   parameter int XFER_TIMEOUT   = 200000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic          clock_100Mhz,
   input  logic          reset,
   ps2_host_tx_if.slave  bus,
   input  logic          Mouse_Clk_In,
   input  logic          Mouse_Data_In,
   output logic          Mouse_Clk_Drive,
   output logic          Mouse_Data_Drive
);

   localparam int CMAX = (INHIBIT_CYCLES > START_TIMEOUT) ?
                         INHIBIT_CYCLES : START_TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int XW   = $clog2(XFER_TIMEOUT + 1);

   localparam logic [CW-1:0] C_INH_DAT  = CW'(INHIBIT_CYCLES - 2);
   localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] C_STO_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [XW-1:0] C_XTO_LAST = XW'(XFER_TIMEOUT - 1);

   ps2_state_e    r_state;
   logic [CW-1:0] r_cnt;
   logic [XW-1:0] r_xcnt;
   logic [3:0]    r_idx;
   logic [9:0]    r_frame;
   logic          r_clk_drv;
   logic          r_dat_drv;
   logic [1:0]    r_err;

   logic w_clk_lvl;
   logic w_clk_fall;
   logic w_dat_lvl;
   logic w_unused_dat_fall;
   logic w_sto;
   logic w_xto;
   logic w_idle_lines;

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk     (clock_100Mhz),
      .rst_n   (reset),
      .i_line  (Mouse_Clk_In),
      .o_level (w_clk_lvl),
      .o_fall  (w_clk_fall)
   );

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dat_sync (
      .clk     (clock_100Mhz),
      .rst_n   (reset),
      .i_line  (Mouse_Data_In),
      .o_level (w_dat_lvl),
      .o_fall  (w_unused_dat_fall)
   );

   assign w_sto        = (r_cnt == C_STO_LAST);
   assign w_xto        = (r_xcnt == C_XTO_LAST);
   assign w_idle_lines = w_clk_lvl & w_dat_lvl;

   // Frame is {stop, parity, data}; the start bit is the REQ data low.
   always_ff @(posedge clock_100Mhz or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_xcnt    <= '0;
         r_idx     <= '0;
         r_frame   <= '0;
         r_clk_drv <= 1'b0;
         r_dat_drv <= 1'b0;
         r_err     <= ERR_NONE;
      end else begin
         if (r_cnt != '1)
            r_cnt <= r_cnt + CW'(1);
         if (r_xcnt != '1)
            r_xcnt <= r_xcnt + XW'(1);
         unique case (r_state)
            ST_IDLE: begin
               if (bus.tx_valid) begin
                  r_frame   <= {1'b1, odd_parity(bus.tx_data),
                                bus.tx_data};
                  r_err     <= ERR_NONE;
                  r_cnt     <= '0;
                  r_clk_drv <= 1'b1;
                  r_state   <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (r_cnt == C_INH_DAT)
                  r_dat_drv <= 1'b1;
               if (r_cnt == C_INH_LAST) begin
                  r_clk_drv <= 1'b0;
                  r_dat_drv <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (w_clk_fall) begin
                  r_dat_drv <= ~r_frame[0];
                  r_idx     <= 4'd1;
                  r_xcnt    <= '0;
                  r_state   <= ST_BITS;
               end else if (w_sto) begin
                  r_dat_drv <= 1'b0;
                  r_err     <= ERR_START;
                  r_state   <= ST_ERR;
               end
            end
            ST_BITS: begin
               if (w_clk_fall) begin
                  r_dat_drv <= ~r_frame[r_idx];
                  if (r_idx == 4'd9)
                     r_state <= ST_ACK;
                  else
                     r_idx <= r_idx + 4'd1;
               end else if (w_xto) begin
                  r_dat_drv <= 1'b0;
                  r_err     <= ERR_XFER;
                  r_state   <= ST_ERR;
               end
            end
            ST_ACK: begin
               if (w_clk_fall) begin
                  if (w_dat_lvl) begin
                     r_err   <= ERR_NACK;
                     r_state <= ST_ERR;
                  end else begin
                     r_state <= ST_WAIT_IDLE;
                  end
               end else if (w_xto) begin
                  r_err   <= ERR_XFER;
                  r_state <= ST_ERR;
               end
            end
            ST_WAIT_IDLE: begin
               if (w_idle_lines) begin
                  r_state <= ST_IDLE;
               end else if (w_xto) begin
                  r_err   <= ERR_XFER;
                  r_state <= ST_ERR;
               end
            end
            ST_ERR: begin
               r_clk_drv <= 1'b0;
               r_dat_drv <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_clk_drv <= 1'b0;
               r_dat_drv <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_ready = (r_state == ST_IDLE);
   assign bus.tx_busy  = (r_state != ST_IDLE);
   assign bus.tx_done  = (r_state == ST_WAIT_IDLE) & w_idle_lines;
   assign bus.tx_error = (r_state == ST_ERR);
   assign bus.err_code = r_err;

   assign Mouse_Clk_Drive  = r_clk_drv;
   assign Mouse_Data_Drive = r_dat_drv;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host and the sampled bits are compared with the byte's framing.
module tb_ps2_host_tx;

   localparam int IC = 20;
   localparam int ST = 500;
   localparam int XT = 2000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;
   logic Mouse_Clk_In;
   logic Mouse_Data_In;
   logic Mouse_Clk_Drive;
   logic Mouse_Data_Drive;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int n_done = 0;
   int n_err = 0;
   int n_bad = 0;
   int err_at = 0;
   logic [1:0] err_drv = 2'b00;

   ps2_host_tx_if u_if ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (IC),
      .START_TIMEOUT  (ST),
      .XFER_TIMEOUT   (XT),
      .SYNC_STAGES    (2)
   ) dut (
      .clock_100Mhz     (clk),
      .reset            (reset),
      .bus              (u_if.slave),
      .Mouse_Clk_In     (Mouse_Clk_In),
      .Mouse_Data_In    (Mouse_Data_In),
      .Mouse_Clk_Drive  (Mouse_Clk_Drive),
      .Mouse_Data_Drive (Mouse_Data_Drive)
   );

   // Open-drain wired-AND of host and device pulls.
   assign Mouse_Clk_In  = ~(Mouse_Clk_Drive | dev_clk_low);
   assign Mouse_Data_In = ~(Mouse_Data_Drive | dev_dat_low);

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (u_if.tx_done)
         n_done <= n_done + 1;
      if (u_if.tx_error) begin
         n_err   <= n_err + 1;
         err_at  <= cyc_n;
         err_drv <= {Mouse_Clk_Drive, Mouse_Data_Drive};
      end
      if ((u_if.tx_done || u_if.tx_error) &&
          (!u_if.tx_busy || (u_if.tx_done && u_if.tx_error)))
         n_bad <= n_bad + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start bit, data LSB first, odd parity, stop.
   function automatic logic [10:0] model_frame(input logic [7:0] b);
      logic par;
      par = ($countones(b) % 2) == 0;
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic send(input logic [7:0] b, input bit hold,
                       output int req_at);
      int lo;
      int dat_first;
      u_if.tx_valid = 1'b1;
      u_if.tx_data  = b;
      cyc(1);
      if (!hold)
         u_if.tx_valid = 1'b0;
      chk("busy_after_accept", {u_if.tx_ready, u_if.tx_busy}, 2'b01);
      lo = 0;
      dat_first = 0;
      while (Mouse_Clk_Drive && lo < 100) begin
         lo++;
         if (Mouse_Data_Drive && dat_first == 0)
            dat_first = lo;
         cyc(1);
      end
      chk("inhibit_len", lo, IC);
      chk("data_low_cycle", dat_first, IC);
      chk("req_data_low", Mouse_Data_Drive, 1'b1);
      req_at = cyc_n;
   endtask

   task automatic dev_frame(input int nfalls, input bit ack_low,
                            output logic [10:0] smp);
      smp = '0;
      cyc(6);
      smp[0] = Mouse_Data_In;
      for (int i = 1; i <= nfalls; i++) begin
         dev_clk_low = 1'b1;
         cyc(20);
         dev_clk_low = 1'b0;
         if (i <= 10)
            smp[i] = Mouse_Data_In;
         if (i == 10)
            dev_dat_low = ack_low;
         if (i == 11)
            dev_dat_low = 1'b0;
         if (i < nfalls)
            cyc(20);
      end
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (u_if.tx_busy && n < limit) begin
         if (u_if.tx_done || u_if.tx_error)
            u_if.tx_valid = 1'b0;
         cyc(1);
         n++;
      end
      chk("idle_wait", u_if.tx_busy, 1'b0);
      chk("ready_back", u_if.tx_ready, 1'b1);
   endtask

   task automatic good_xfer(input logic [7:0] b, input bit hold);
      int req_at;
      int d0;
      int e0;
      logic [10:0] smp;
      d0 = n_done;
      e0 = n_err;
      send(b, hold, req_at);
      dev_frame(11, 1'b1, smp);
      wait_idle(200);
      chk($sformatf("frame_%02h", b), smp, model_frame(b));
      chk("done_once", n_done - d0, 1);
      chk("no_error", n_err - e0, 0);
      chk("code_ok", u_if.err_code, 2'd0);
      chk("drives_rel", {Mouse_Clk_Drive, Mouse_Data_Drive}, 2'b00);
   endtask

   initial begin
      int req_at;
      int d0;
      int e0;
      logic [10:0] smp;
      logic [7:0] rb;
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = 8'h00;
      cyc(3);
      chk("reset_ready_busy", {u_if.tx_ready, u_if.tx_busy}, 2'b10);
      chk("reset_pulses", {u_if.tx_done, u_if.tx_error}, 2'b00);
      chk("reset_code", u_if.err_code, 2'd0);
      chk("reset_drives", {Mouse_Clk_Drive, Mouse_Data_Drive}, 2'b00);
      reset = 1'b1;
      cyc(3);

      good_xfer(8'hF4, 1'b0);
      good_xfer(8'h00, 1'b0);
      for (int k = 0; k < 4; k++) begin
         rb = 8'($urandom_range(0, 255));
         good_xfer(rb, 1'b0);
      end

      // Device never clocks.
      e0 = n_err;
      d0 = n_done;
      send(8'h3C, 1'b0, req_at);
      wait_idle(ST + 100);
      chk("sto_err", n_err - e0, 1);
      chk("sto_no_done", n_done - d0, 0);
      chk("sto_code", u_if.err_code, 2'd1);
      chk("sto_cycle", err_at - req_at, ST);
      chk("sto_drives", err_drv, 2'b00);

      // Device stops after five edges.
      e0 = n_err;
      send(8'hA5, 1'b0, req_at);
      dev_frame(5, 1'b1, smp);
      wait_idle(XT + 200);
      chk("xto_err", n_err - e0, 1);
      chk("xto_code", u_if.err_code, 2'd2);
      chk("xto_window", (err_at - req_at >= XT) &&
                        (err_at - req_at <= XT + 15), 1'b1);
      chk("xto_drives", err_drv, 2'b00);

      // Device leaves data high at the ack edge.
      e0 = n_err;
      d0 = n_done;
      send(8'h12, 1'b0, req_at);
      dev_frame(11, 1'b0, smp);
      wait_idle(200);
      chk("nack_frame", smp, model_frame(8'h12));
      chk("nack_err", n_err - e0, 1);
      chk("nack_no_done", n_done - d0, 0);
      chk("nack_code", u_if.err_code, 2'd3);

      // Asynchronous reset in the middle of the data bits.
      e0 = n_err;
      d0 = n_done;
      send(8'h00, 1'b0, req_at);
      dev_frame(4, 1'b1, smp);
      chk("mid_bits_data_low", Mouse_Data_Drive, 1'b1);
      #2 reset = 1'b0;
      #1 chk("rst_drives", {Mouse_Clk_Drive, Mouse_Data_Drive}, 2'b00);
      cyc(2);
      reset = 1'b1;
      cyc(2);
      chk("rst_ready", {u_if.tx_ready, u_if.tx_busy}, 2'b10);
      chk("rst_no_pulse", (n_err - e0) + (n_done - d0), 0);

      // tx_valid held through the whole transfer.
      good_xfer(8'hFF, 1'b1);
      cyc(3);
      chk("no_reaccept", {u_if.tx_ready, Mouse_Clk_Drive}, 2'b10);
      chk("pulse_rules", n_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the mouse using the PS/2 host-request protocol: inhibit, request-to-send, 8 data bits, odd parity, stop, then device ack. It sits beside the mouse receiver in the mouse controller. Its outputs drive the open-drain Mouse_Clk/Mouse_Data pads through the top-level tristates. At power-up it issues commands such as 0xF4 (enable data reporting).

## Interface
Parameters:
- INHIBIT_CYCLES, 10000: clock-low hold (100 µs at 100 MHz).
- START_TIMEOUT, 1500000: maximum wait for the device's first clock fall after request (15 ms).
- XFER_TIMEOUT, 200000: maximum time from first fall to lines idle (2 ms).
- SYNC_STAGES, 2: flops in each input synchronizer (≥2).

Ports:
- clock_100Mhz  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  command byte.
- tx_ready  out  1  high only in IDLE; a transfer is accepted on tx_valid & tx_ready.
- tx_busy  out  1  high from accept until return to IDLE; gates the receiver.
- tx_done  out  1  one-cycle pulse on successful acked transfer.
- tx_error  out  1  one-cycle pulse on failure.
- err_code  out  2  0 none, 1 start timeout, 2 transfer timeout, 3 nack; held until next accept.
- Mouse_Clk_In  in  1  raw pad value of the PS/2 clock (asynchronous).
- Mouse_Data_In  in  1  raw pad value of the PS/2 data line.
- Mouse_Clk_Drive  out  1  1 = pull clock low; 0 = release.
- Mouse_Data_Drive  out  1  1 = pull data low; 0 = release.

## Operation
- Reset: state IDLE; tx_ready=1; all other outputs 0; err_code=0.
- Falling edge = synchronized clock was 1 and is now 0. Only falling edges advance the transfer.
- IDLE:
  - On accept, latch tx_data and parity = ~^tx_data.
  - Clear err_code and go to INHIBIT.
  - tx_valid is ignored while not in IDLE.
- INHIBIT:
  - Mouse_Clk_Drive=1 for INHIBIT_CYCLES cycles.
  - Mouse_Data_Drive also rises on the final inhibit cycle.
  - Then go to REQ.
- REQ:
  - Release clock; keep data low (start bit).
  - Start the start timer.
  - First falling edge: drive data bit 0, start the transfer timer, go to BITS.
- BITS, counter idx:
  - Each following falling edge presents the next value: data bits 1–7, then parity, then stop (release data).
  - Mouse_Data_Drive = ~bit_value.
  - After the stop edge, go to ACK.
- ACK:
  - The next falling edge samples synchronized data.
  - Data 0: go to WAIT_IDLE.
  - Data 1: nack, go to ERR with code 3.
- WAIT_IDLE:
  - When the synchronized clock and data are both 1, pulse tx_done and go to IDLE.
- ERR:
  - Release both lines, pulse tx_error, set err_code, then go to IDLE.
  - One cycle only.
- Timeouts:
  - Start timer expiry in REQ: error code 1.
  - Transfer timer expiry in BITS/ACK/WAIT_IDLE: error code 2.
- Simultaneous events: a falling edge on the same cycle as a timer expiry is processed; the timeout is ignored that cycle.
- Reset mid-transfer releases both lines immediately (asynchronously). No pulse is emitted.
- Counters are sized with $clog2 of their limit and saturate; they never wrap.

## Timing
- Accept at cycle N:
  - tx_ready=0 and tx_busy=1 from N+1.
  - Mouse_Clk_Drive=1 during N+1 … N+INHIBIT_CYCLES.
  - Mouse_Data_Drive=1 from N+INHIBIT_CYCLES.
- Input-to-edge latency is SYNC_STAGES+1 cycles. Data updates one cycle after edge detection, well inside the ≥30 µs half-period.
- tx_done/tx_error:
  - Exactly one cycle wide.
  - Mutually exclusive.
  - Coincide with the last tx_busy=1 cycle.
  - tx_ready returns the following cycle.
- Drive outputs are registered, with no combinational path from inputs.

## Structure
- ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, BITS, ACK, WAIT_IDLE, ERR);
  - the err_code constants;
  - command constants: CMD_RESET 0xFF, CMD_ENABLE 0xF4, CMD_SET_RATE 0xF3, RESP_ACK 0xFA.
- Sub-module ps2_line_sync (SYNC_STAGES flops plus a falling-edge pulse) is instantiated for clock and data. The mouse receiver shares it.

## Test plan
Run with INHIBIT_CYCLES=20, START_TIMEOUT=500, XFER_TIMEOUT=2000; the bench device model clocks with a 40-cycle period.
- Send 0xF4, device acks → bits sampled on rises are 0, 0,0,1,0,1,1,1,1, parity 0, stop 1. tx_done pulses once; err_code=0.
- Send 0x00 → parity bit sampled as 1. Check clock low exactly 20 cycles and data low on cycle 20.
- Device never clocks → tx_error at cycle 500 after REQ entry, err_code=1, both drives 0.
- Device stops after 5 edges → tx_error when the transfer timer expires, err_code=2.
- Device leaves data high at the ack edge → tx_error, err_code=3, no tx_done.
- Reset low mid-BITS → drives 0 the same cycle. After release: tx_ready=1, and a new 0xFF transfer completes normally. tx_valid held during busy is never double-accepted.
